// File: rtl/fetch_rf_arb.sv
// Single-port fetch RF arbiter: write-priority grant with read starvation guard
// and a 2-cycle registered read-return pipeline. The RF itself lives in the parent.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module fetch_rf_arb #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 64*`PIXEL_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_dval_o,
  output logic              rf_wr_en_o,
  output logic [ADDR_W-1:0] rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_wr_data_o,
  output logic              rf_rd_en_o,
  output logic [ADDR_W-1:0] rf_rd_addr_o,
  input  logic [DATA_W-1:0] rf_rd_data_i,
  output logic [2:0]        starve_cnt_o,
  output logic              busy_o
);

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  logic [2:0]        r_starve;
  logic [2:1]        r_vld_pipe;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_wr_gnt;
  logic              w_rd_gnt;

  // Writes win unless a waiting read has already been passed over SMAX times.
  always_comb begin
    w_wr_gnt = rstn && wr_req_i && (!rd_req_i || (r_starve < SMAX));
    w_rd_gnt = rstn && rd_req_i && !w_wr_gnt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starve <= '0;
    end else if (!rd_req_i || w_rd_gnt) begin
      r_starve <= '0;
    end else if (w_wr_gnt && (r_starve < SMAX)) begin
      r_starve <= r_starve + 3'd1;
    end
  end

  // Stage 1 marks the RF read in flight; stage 2 holds the captured row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      r_rd_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_rd_gnt};
      if (r_vld_pipe[1]) r_rd_data <= rf_rd_data_i;
    end
  end

  assign wr_gnt_o     = w_wr_gnt;
  assign rd_gnt_o     = w_rd_gnt;
  assign rf_wr_en_o   = w_wr_gnt;
  assign rf_rd_en_o   = w_rd_gnt;
  assign rf_wr_addr_o = wr_addr_i;
  assign rf_wr_data_o = wr_data_i;
  assign rf_rd_addr_o = rd_addr_i;
  assign rd_data_o    = r_rd_data;
  assign rd_dval_o    = r_vld_pipe[2];
  assign busy_o       = |r_vld_pipe;
  assign starve_cnt_o = r_starve;

endmodule

// File: tb/tb_fetch_rf_arb.sv
// Bench for fetch_rf_arb: behavioural RF + transaction-level reference model,
// directed scenarios followed by random request traffic.
module tb_fetch_rf_arb;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 512;
  localparam int SMAX   = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              wr_req_i = 1'b0, rd_req_i = 1'b0;
  logic [ADDR_W-1:0] wr_addr_i = '0, rd_addr_i = '0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              wr_gnt_o, rd_gnt_o, rd_dval_o, busy_o;
  logic              rf_wr_en_o, rf_rd_en_o;
  logic [ADDR_W-1:0] rf_wr_addr_o, rf_rd_addr_o;
  logic [DATA_W-1:0] rd_data_o, rf_wr_data_o, rf_rd_data_i;
  logic [2:0]        starve_cnt_o;

  fetch_rf_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_data_o(rd_data_o), .rd_dval_o(rd_dval_o),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
    .rf_rd_en_o(rf_rd_en_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_i(rf_rd_data_i),
    .starve_cnt_o(starve_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RF with synchronous read.
  logic [DATA_W-1:0] rf_mem [128];
  always @(posedge clk) begin
    if (rf_wr_en_o) rf_mem[rf_wr_addr_o] <= rf_wr_data_o;
    if (rf_rd_en_o) rf_rd_data_i <= rf_mem[rf_rd_addr_o];
  end

  // Reference model: row contents as seen in grant order, pending returns.
  typedef struct { int due; logic [DATA_W-1:0] d; } ret_t;
  logic [DATA_W-1:0] ref_mem [128];
  ret_t ret_q[$];
  int   sc = 0, cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   n_gnt = 0, n_dval = 0, n_flush = 0;
  bit   wg_last = 0, rg_last = 0;

  function automatic logic [DATA_W-1:0] rnd();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check mid-cycle, advance the model across posedge.
  task automatic step();
    bit ewg, erg, edv;
    logic [DATA_W-1:0] ed;
    #1;
    if (!rstn) begin
      n_flush += ret_q.size();
      ret_q.delete();
      sc = 0;
    end
    ewg = rstn && wr_req_i && (!rd_req_i || sc < SMAX);
    erg = rstn && rd_req_i && !ewg;
    edv = (ret_q.size() > 0) && (ret_q[0].due == cyc);
    ed  = edv ? ret_q[0].d : '0;
    chk("wr_gnt", DATA_W'(wr_gnt_o), DATA_W'(ewg));
    chk("rd_gnt", DATA_W'(rd_gnt_o), DATA_W'(erg));
    chk("rf_wr_en", DATA_W'(rf_wr_en_o), DATA_W'(ewg));
    chk("rf_rd_en", DATA_W'(rf_rd_en_o), DATA_W'(erg));
    chk("one_port", DATA_W'(rf_wr_en_o & rf_rd_en_o), '0);
    chk("starve_cnt", DATA_W'(starve_cnt_o), DATA_W'(sc));
    chk("busy", DATA_W'(busy_o), DATA_W'(ret_q.size() > 0));
    chk("rd_dval", DATA_W'(rd_dval_o), DATA_W'(edv));
    if (edv) begin
      chk("rd_data", rd_data_o, ed);
      void'(ret_q.pop_front());
    end
    if (ewg) chk("rf_wr_addr", DATA_W'(rf_wr_addr_o), DATA_W'(wr_addr_i));
    if (erg) chk("rf_rd_addr", DATA_W'(rf_rd_addr_o), DATA_W'(rd_addr_i));
    if (rd_gnt_o) n_gnt++;
    if (rd_dval_o) n_dval++;
    if (ewg) ref_mem[wr_addr_i] = wr_data_i;
    if (erg) ret_q.push_back('{due: cyc + 2, d: ref_mem[rd_addr_i]});
    if (!rd_req_i || erg) sc = 0;
    else if (ewg && sc < SMAX) sc++;
    wg_last = ewg;
    rg_last = erg;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wr_req_i = 0; rd_req_i = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [DATA_W-1:0] a;
    for (int k = 0; k < 128; k++) begin
      a = rnd();
      rf_mem[k]  = a;
      ref_mem[k] = a;
    end
    // Reset state with requests asserted: no grants allowed.
    @(negedge clk);
    wr_req_i = 1; rd_req_i = 1;
    step();
    chk("rst_rd_data", rd_data_o, '0);
    step();
    rstn = 1;
    idle(2);

    // 128 consecutive writes over the full address range.
    for (int k = 0; k < 128; k++) begin
      wr_req_i = 1; wr_addr_i = ADDR_W'(k); wr_data_i = rnd();
      step();
    end
    idle(2);

    // Write addr 5, then read addr 5: newly written row returns.
    a = rnd();
    wr_req_i = 1; wr_addr_i = 7'd5; wr_data_i = a;
    step();
    wr_req_i = 0; rd_req_i = 1; rd_addr_i = 7'd5;
    step();
    rd_req_i = 0;
    step();
    step();
    chk("wr_then_rd", rd_data_o, a);
    idle(2);

    // Both requests held: 4 writes then 1 read, repeating.
    rd_req_i = 1; rd_addr_i = 7'd9;
    wr_req_i = 1; wr_addr_i = 7'd20; wr_data_i = rnd();
    for (int k = 0; k < 15; k++) begin
      step();
      if (wg_last) begin wr_addr_i = ADDR_W'($urandom_range(0, 127)); wr_data_i = rnd(); end
    end
    idle(3);

    // Read in T, write same row in T+1: old row returns.
    a = ref_mem[33];
    rd_req_i = 1; rd_addr_i = 7'd33;
    step();
    rd_req_i = 0; wr_req_i = 1; wr_addr_i = 7'd33; wr_data_i = rnd();
    step();
    wr_req_i = 0;
    step();
    chk("rd_then_wr", rd_data_o, a);
    idle(2);

    // Three back-to-back reads, then reset mid-flight.
    for (int k = 0; k < 3; k++) begin
      rd_req_i = 1; rd_addr_i = ADDR_W'(40 + k);
      step();
    end
    rd_req_i = 0;
    rstn = 0;
    step();
    chk("rst_mid_data", rd_data_o, '0);
    step();
    rstn = 1;
    idle(4);

    // Random traffic; hold address/data while a request waits.
    for (int k = 0; k < 2000; k++) begin
      if (!(wr_req_i && !wg_last)) begin
        wr_req_i = ($urandom_range(0, 99) < 60);
        wr_addr_i = ADDR_W'($urandom_range(0, 127)); wr_data_i = rnd();
      end
      if (!(rd_req_i && !rg_last)) begin
        rd_req_i = ($urandom_range(0, 99) < 50);
        rd_addr_i = ADDR_W'($urandom_range(0, 127));
      end
      step();
    end
    idle(4);
    chk("dval_vs_gnt", DATA_W'(n_dval), DATA_W'(n_gnt - n_flush));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
